// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and stall generator for a 5-stage pipeline (D/E/M/W tags).
// Define FWD_HAZARD_FORWARD_EN to build the bypass network; otherwise dependencies stall until writeback.

`ifndef IROP
`define IROP  6'b000000
`endif
`ifndef IADDI
`define IADDI 6'b001000
`endif
`ifndef IANDI
`define IANDI 6'b001100
`endif
`ifndef IORI
`define IORI  6'b001101
`endif
`ifndef ILW
`define ILW   6'b100011
`endif
`ifndef ISW
`define ISW   6'b101011
`endif

// Resolves one source operand against the in-flight destination tags.
module fwd_hazard_src (
  input  logic       used,
  input  logic [4:0] src,
  input  logic [4:0] e_dst,
  input  logic       e_load,
  input  logic [4:0] m_dst,
  input  logic [4:0] w_dst,
  output logic [1:0] sel,
  output logic       hazard
);
  logic live;
  logic hit_e, hit_m, hit_w, load_use;

  assign live     = used && (src != 5'd0);
  assign hit_e    = live && (src == e_dst);
  assign hit_m    = live && (src == m_dst);
  assign hit_w    = live && (src == w_dst);
  assign load_use = hit_e && e_load;

  always_comb begin
    sel    = 2'b00;
    hazard = 1'b0;
`ifdef FWD_HAZARD_FORWARD_EN
    // A load in E has no data yet; anything else is bypassed, youngest first.
    hazard = load_use;
    if (hit_e && !e_load) sel = 2'b01;
    else if (hit_m)       sel = 2'b10;
    else if (hit_w)       sel = 2'b11;
`else
    hazard = load_use || hit_e || hit_m || hit_w;
`endif
  end
endmodule

module fwd_hazard_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] D_op,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [4:0] d_dstE,
  output logic [1:0] fwdA,
  output logic [1:0] fwdB,
  output logic       stall,
  output logic       E_bubble
);
  localparam int NUM_SRC = 2;  // lane 0 = rs, lane 1 = rt

  logic [4:0] E_dst, M_dst, W_dst;
  logic       E_load, M_load;

  logic [NUM_SRC-1:0]      used, hazard;
  logic [NUM_SRC-1:0][4:0] src;
  logic [NUM_SRC-1:0][1:0] sel;
  logic                    unused_m_load;

  always_comb begin
    used = '0;
    case (D_op)
      `IROP, `ISW:                  used = 2'b11;
      `IADDI, `IANDI, `IORI, `ILW:  used = 2'b01;
      default:                      used = 2'b00;
    endcase
  end

  assign src = {D_rt, D_rs};

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_hazard_src u_src (
        .used   (used[i]),
        .src    (src[i]),
        .e_dst  (E_dst),
        .e_load (E_load),
        .m_dst  (M_dst),
        .w_dst  (W_dst),
        .sel    (sel[i]),
        .hazard (hazard[i])
      );
    end
  endgenerate

  assign stall    = |hazard;
  assign E_bubble = stall;
  assign fwdA     = stall ? 2'b00 : sel[0];
  assign fwdB     = stall ? 2'b00 : sel[1];

  // M_load travels with the M tag for downstream visibility only.
  assign unused_m_load = M_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      E_dst  <= 5'd0;
      E_load <= 1'b0;
      M_dst  <= 5'd0;
      M_load <= 1'b0;
      W_dst  <= 5'd0;
    end else begin
      if (stall) begin
        E_dst  <= 5'd0;
        E_load <= 1'b0;
      end else begin
        E_dst  <= d_dstE;
        E_load <= (D_op == `ILW);
      end
      M_dst  <= E_dst;
      M_load <= E_load;
      W_dst  <= M_dst;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; expectations follow whichever build config is compiled.

`ifndef IROP
`define IROP  6'b000000
`endif
`ifndef IADDI
`define IADDI 6'b001000
`endif
`ifndef IANDI
`define IANDI 6'b001100
`endif
`ifndef IORI
`define IORI  6'b001101
`endif
`ifndef ILW
`define ILW   6'b100011
`endif
`ifndef ISW
`define ISW   6'b101011
`endif

module tb_fwd_hazard_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] D_op;
  logic [4:0] D_rs, D_rt, d_dstE;
  logic [1:0] fwdA, fwdB;
  logic       stall, E_bubble;

  int n_assert = 0;
  int n_fail   = 0;

  // {fwdA, fwdB, stall, E_bubble}
  localparam logic [5:0] NONE  = 6'b00_00_0_0;
  localparam logic [5:0] STALL = 6'b00_00_1_1;
  localparam logic [5:0] NOP   = 6'h3f;

  fwd_hazard_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .D_op     (D_op),
    .D_rs     (D_rs),
    .D_rt     (D_rt),
    .d_dstE   (d_dstE),
    .fwdA     (fwdA),
    .fwdB     (fwdB),
    .stall    (stall),
    .E_bubble (E_bubble)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {fwdA, fwdB, stall, E_bubble};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed fwdA/fwdB/stall/bubble=%b required %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] dst);
    D_op = op; D_rs = rs; D_rt = rt; d_dstE = dst;
  endtask

  // Apply one D-stage instruction, check at the falling edge, then let it clock.
  task automatic step(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] dst, input logic [5:0] exp, input string tag);
    drive(op, rs, rt, dst);
    @(negedge clk);
    chk(tag, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(NOP, 5'd0, 5'd0, 5'd0);
    #3;
    chk("reset_async", NONE);
    @(posedge clk); #1;
    chk("reset_hold", NONE);
    rst_n = 1'b1;

`ifdef FWD_HAZARD_FORWARD_EN
    step(`IADDI, 5'd0,  5'd0,  5'd8,  NONE,         "addi8");
    step(`IROP,  5'd8,  5'd9,  5'd0,  6'b01_00_0_0, "e_fwd_rs");
    step(`ILW,   5'd0,  5'd0,  5'd10, NONE,         "lw10");
    step(`ISW,   5'd1,  5'd10, 5'd0,  STALL,        "load_use");
    step(`ISW,   5'd1,  5'd10, 5'd0,  6'b00_10_0_0, "after_load_use_m");
    step(`IROP,  5'd10, 5'd0,  5'd0,  6'b11_00_0_0, "w_fwd");
    step(`IADDI, 5'd0,  5'd0,  5'd5,  NONE,         "addi5");
    step(`IORI,  5'd0,  5'd0,  5'd5,  NONE,         "ori5");
    step(`IROP,  5'd5,  5'd5,  5'd0,  6'b01_01_0_0, "youngest_rs_eq_rt");
    step(`IROP,  5'd5,  5'd0,  5'd0,  6'b10_00_0_0, "m_over_w");
    step(`IADDI, 5'd0,  5'd0,  5'd0,  NONE,         "addi_r0");
    step(`IROP,  5'd0,  5'd0,  5'd0,  NONE,         "reg0_no_fwd");
    step(`IADDI, 5'd0,  5'd0,  5'd6,  NONE,         "addi6");
    step(`IADDI, 5'd0,  5'd6,  5'd0,  NONE,         "rt_unused");
    step(NOP,    5'd6,  5'd6,  5'd0,  NONE,         "other_op");
`else
    step(`IADDI, 5'd0,  5'd0,  5'd7,  NONE,  "addi7");
    step(`IROP,  5'd7,  5'd0,  5'd0,  STALL, "dep_e");
    step(`IROP,  5'd7,  5'd0,  5'd0,  STALL, "dep_m");
    step(`IROP,  5'd7,  5'd0,  5'd0,  STALL, "dep_w");
    step(`IROP,  5'd7,  5'd0,  5'd0,  NONE,  "dep_clear");
    step(`IADDI, 5'd0,  5'd0,  5'd9,  NONE,  "addi9");
    step(`IADDI, 5'd0,  5'd9,  5'd0,  NONE,  "rt_unused");
    step(NOP,    5'd9,  5'd9,  5'd0,  NONE,  "other_op");
    step(`IROP,  5'd0,  5'd9,  5'd0,  STALL, "rt_dep_w");
    step(`IADDI, 5'd0,  5'd0,  5'd0,  NONE,  "addi_r0");
    step(`IROP,  5'd0,  5'd0,  5'd0,  NONE,  "reg0_no_stall");
    step(`ILW,   5'd0,  5'd0,  5'd10, NONE,  "lw10");
    step(`ISW,   5'd1,  5'd10, 5'd0,  STALL, "lw_dep_e");
    step(`ISW,   5'd1,  5'd10, 5'd0,  STALL, "lw_dep_m");
    step(`ISW,   5'd1,  5'd10, 5'd0,  STALL, "lw_dep_w");
    step(`ISW,   5'd1,  5'd10, 5'd0,  NONE,  "lw_dep_clear");
`endif

    // Reset dropped in the middle of a load-use stall.
    step(`ILW, 5'd0, 5'd0, 5'd12, NONE, "lw12");
    drive(`ISW, 5'd12, 5'd0, 5'd0);
    @(negedge clk);
    chk("pre_reset_stall", STALL);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_stall", NONE);
    @(posedge clk); #1;
    chk("reset_mid_hold", NONE);
    rst_n = 1'b1;
    step(`ISW, 5'd12, 5'd0, 5'd0, NONE, "post_reset_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
